ikaopll_sample_acc: RTL and testbench

IKAOPLL_SAMPLE_ACC -- requirements
Module: ikaopll_sample_acc

---
 rtl/ikaopll_pkg.sv | 21 ++
 rtl/ikaopll_sample_acc_if.sv | 25 ++
 rtl/ikaopll_sample_acc_core.sv | 129 ++++++++++++
 rtl/ikaopll_sat.sv | 28 ++
 rtl/ikaopll_sample_acc.sv | 43 ++++
 tb/tb_ikaopll_sample_acc.sv | 217 +++++++++++++++++++++
 6 files changed

// File: rtl/ikaopll_pkg.sv
// Shared constants and state type for the OPLL sample accumulator.
// Widths cover 9 slots of 10-bit samples per channel and the gained mix.
package ikaopll_pkg;

  localparam int SLOTS_PER_CH = 9;
  localparam int DAC_W        = 10;
  localparam int CNT_W        = 4;
  localparam int ACC_W        = 14;
  localparam int SUM_W        = 18;
  localparam int OUT_W        = 16;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    ACCUM     = 1'b1
  } acc_state_t;

  function automatic logic signed [ACC_W-1:0] dac_to_acc(input logic signed [DAC_W-1:0] x);
    return ACC_W'(x);
  endfunction

endpackage

// File: rtl/ikaopll_sample_acc_if.sv
// Sample strobe / mixed output bundle between the pin wrapper and the core.
interface ikaopll_sample_acc_if;
  import ikaopll_pkg::*;

  logic                    frame_start;
  logic                    mo_sample;
  logic signed [DAC_W-1:0] mo;
  logic                    ro_sample;
  logic signed [DAC_W-1:0] ro;
  logic signed [OUT_W-1:0] sample;
  logic                    sample_valid;
  logic                    clip;
  logic                    overrun;

  modport master (
    output frame_start, mo_sample, mo, ro_sample, ro,
    input  sample, sample_valid, clip, overrun
  );

  modport slave (
    input  frame_start, mo_sample, mo, ro_sample, ro,
    output sample, sample_valid, clip, overrun
  );

endinterface

// File: rtl/ikaopll_sample_acc_core.sv
// Per-frame MO/RO accumulation, stage-1 capture and gained/saturated stage-2 output.
// A frame-start both closes the running frame and opens the next one.
module ikaopll_sample_acc_core
  import ikaopll_pkg::*;
#(
  parameter int MO_GAIN = 1,
  parameter int RO_GAIN = 2
) (
  input logic                 clk,
  input logic                 rst,
  ikaopll_sample_acc_if.slave bus
);

  localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(SLOTS_PER_CH);
  localparam logic signed [SUM_W-1:0] MO_G    = SUM_W'(MO_GAIN);
  localparam logic signed [SUM_W-1:0] RO_G    = SUM_W'(RO_GAIN);

  acc_state_t              state_q, state_d;
  logic signed [ACC_W-1:0] mo_acc_q, mo_acc_d, ro_acc_q, ro_acc_d;
  logic [CNT_W-1:0]        mo_cnt_q, mo_cnt_d, ro_cnt_q, ro_cnt_d;
  logic signed [ACC_W-1:0] s1_mo_q, s1_mo_d, s1_ro_q, s1_ro_d;
  logic                    s1_vld_q, s1_vld_d;
  logic signed [OUT_W-1:0] sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic                    clip_q, clip_d;
  logic                    ovr_q, ovr_d;

  logic signed [SUM_W-1:0] mix_sum;
  logic signed [OUT_W-1:0] mix_sat;
  logic                    mix_clip;

  always_comb begin
    state_d  = state_q;
    mo_acc_d = mo_acc_q;
    ro_acc_d = ro_acc_q;
    mo_cnt_d = mo_cnt_q;
    ro_cnt_d = ro_cnt_q;
    s1_mo_d  = s1_mo_q;
    s1_ro_d  = s1_ro_q;
    s1_vld_d = 1'b0;
    ovr_d    = ovr_q;
    unique case (state_q)
      WAIT_SYNC: begin
        if (bus.frame_start) state_d = ACCUM;
      end
      ACCUM: begin
        if (bus.frame_start) begin
          s1_mo_d  = mo_acc_q;
          s1_ro_d  = ro_acc_q;
          s1_vld_d = 1'b1;
          mo_acc_d = '0;
          ro_acc_d = '0;
          mo_cnt_d = '0;
          ro_cnt_d = '0;
        end
        // Strobes apply after the frame clear so a coincident one opens the new frame.
        if (bus.mo_sample) begin
          if (mo_cnt_d == CNT_MAX) begin
            ovr_d = 1'b1;
          end else begin
            mo_acc_d = mo_acc_d + dac_to_acc(bus.mo);
            mo_cnt_d = mo_cnt_d + 1'b1;
          end
        end
        if (bus.ro_sample) begin
          if (ro_cnt_d == CNT_MAX) begin
            ovr_d = 1'b1;
          end else begin
            ro_acc_d = ro_acc_d + dac_to_acc(bus.ro);
            ro_cnt_d = ro_cnt_d + 1'b1;
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_comb begin
    mix_sum  = SUM_W'(s1_mo_q) * MO_G + SUM_W'(s1_ro_q) * RO_G;
    sample_d = s1_vld_q ? mix_sat : sample_q;
    valid_d  = s1_vld_q;
    clip_d   = s1_vld_q & mix_clip;
  end

  ikaopll_sat #(
    .IN_W  (SUM_W),
    .RES_W (OUT_W)
  ) u_sat (
    .i_sum  (mix_sum),
    .o_sat  (mix_sat),
    .o_clip (mix_clip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_SYNC;
      mo_acc_q <= '0;
      ro_acc_q <= '0;
      mo_cnt_q <= '0;
      ro_cnt_q <= '0;
      s1_mo_q  <= '0;
      s1_ro_q  <= '0;
      s1_vld_q <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      clip_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mo_acc_q <= mo_acc_d;
      ro_acc_q <= ro_acc_d;
      mo_cnt_q <= mo_cnt_d;
      ro_cnt_q <= ro_cnt_d;
      s1_mo_q  <= s1_mo_d;
      s1_ro_q  <= s1_ro_d;
      s1_vld_q <= s1_vld_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      clip_q   <= clip_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.clip         = clip_q;
  assign bus.overrun      = ovr_q;

endmodule

// File: rtl/ikaopll_sat.sv
// Clamp a wide signed sum to the output range and flag when clamping happened.
module ikaopll_sat
  import ikaopll_pkg::*;
#(
  parameter int IN_W  = SUM_W,
  parameter int RES_W = OUT_W
) (
  input  logic signed [IN_W-1:0]  i_sum,
  output logic signed [RES_W-1:0] o_sat,
  output logic                    o_clip
);

  localparam logic signed [IN_W-1:0] MAXV = IN_W'((1 <<< (RES_W-1)) - 1);
  localparam logic signed [IN_W-1:0] MINV = ~MAXV;

  always_comb begin
    o_sat  = i_sum[RES_W-1:0];
    o_clip = 1'b0;
    if (i_sum > MAXV) begin
      o_sat  = MAXV[RES_W-1:0];
      o_clip = 1'b1;
    end else if (i_sum < MINV) begin
      o_sat  = MINV[RES_W-1:0];
      o_clip = 1'b1;
    end
  end

endmodule

// File: rtl/ikaopll_sample_acc.sv
// Pin-level wrapper: maps the OPLL-style ports onto the internal bundle and core.
module ikaopll_sample_acc
  import ikaopll_pkg::*;
#(
  parameter int MO_GAIN = 1,
  parameter int RO_GAIN = 2
) (
  input  logic                    i_EMUCLK,
  input  logic                    i_RST,
  input  logic                    i_FRAME_START,
  input  logic                    i_MO_SAMPLE,
  input  logic signed [DAC_W-1:0] i_MO,
  input  logic                    i_RO_SAMPLE,
  input  logic signed [DAC_W-1:0] i_RO,
  output logic signed [OUT_W-1:0] o_SAMPLE,
  output logic                    o_SAMPLE_VALID,
  output logic                    o_CLIP,
  output logic                    o_OVERRUN
);

  ikaopll_sample_acc_if bus ();

  assign bus.frame_start = i_FRAME_START;
  assign bus.mo_sample   = i_MO_SAMPLE;
  assign bus.mo          = i_MO;
  assign bus.ro_sample   = i_RO_SAMPLE;
  assign bus.ro          = i_RO;

  assign o_SAMPLE        = bus.sample;
  assign o_SAMPLE_VALID  = bus.sample_valid;
  assign o_CLIP          = bus.clip;
  assign o_OVERRUN       = bus.overrun;

  ikaopll_sample_acc_core #(
    .MO_GAIN (MO_GAIN),
    .RO_GAIN (RO_GAIN)
  ) u_core (
    .clk (i_EMUCLK),
    .rst (i_RST),
    .bus (bus.slave)
  );

endmodule

// File: tb/tb_ikaopll_sample_acc.sv
// Drives two gain variants with directed and random frames; a frame-level model predicts outputs.
module tb_ikaopll_sample_acc;
  import ikaopll_pkg::*;

  localparam int GA_MO = 1, GA_RO = 2;
  localparam int GB_MO = 4, GB_RO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ikaopll_sample_acc_if bus ();

  logic signed [15:0] samp_a, samp_b;
  logic vld_a, vld_b, clip_a, clip_b, ov_a, ov_b;

  ikaopll_sample_acc #(.MO_GAIN(GA_MO), .RO_GAIN(GA_RO)) dut_a (
    .i_EMUCLK(clk), .i_RST(rst), .i_FRAME_START(bus.frame_start),
    .i_MO_SAMPLE(bus.mo_sample), .i_MO(bus.mo), .i_RO_SAMPLE(bus.ro_sample), .i_RO(bus.ro),
    .o_SAMPLE(samp_a), .o_SAMPLE_VALID(vld_a), .o_CLIP(clip_a), .o_OVERRUN(ov_a));

  ikaopll_sample_acc #(.MO_GAIN(GB_MO), .RO_GAIN(GB_RO)) dut_b (
    .i_EMUCLK(clk), .i_RST(rst), .i_FRAME_START(bus.frame_start),
    .i_MO_SAMPLE(bus.mo_sample), .i_MO(bus.mo), .i_RO_SAMPLE(bus.ro_sample), .i_RO(bus.ro),
    .o_SAMPLE(samp_b), .o_SAMPLE_VALID(vld_b), .o_CLIP(clip_b), .o_OVERRUN(ov_b));

  typedef struct {
    int due;
    int sa;
    bit ca;
    int sb;
    bit cb;
  } res_t;

  res_t pend[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  bit   synced, ov;
  int   mo_sum, mo_n, ro_sum, ro_n;
  int   exp_sa, exp_sb;
  int   last_a, last_b, last_vcyc, last_fs, nvld_a;
  bit   last_ca, last_cb;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    synced = 0; ov = 0;
    mo_sum = 0; mo_n = 0; ro_sum = 0; ro_n = 0;
    exp_sa = 0; exp_sb = 0;
    pend.delete();
  endtask

  // One clock: check what is visible now, drive this cycle's inputs, advance the model.
  task automatic step(input bit r, input bit fs, input bit ms, input int mv, input bit rs, input int rv);
    bit ev, eca, ecb;
    int ta, tb;
    res_t x;
    @(negedge clk);
    ev = 0; eca = 0; ecb = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = 1; exp_sa = pend[0].sa; exp_sb = pend[0].sb;
      eca = pend[0].ca; ecb = pend[0].cb;
      void'(pend.pop_front());
    end
    chk("valid_a", int'(vld_a), int'(ev));
    chk("valid_b", int'(vld_b), int'(ev));
    chk("sample_a", int'(samp_a), exp_sa);
    chk("sample_b", int'(samp_b), exp_sb);
    chk("clip_a", int'(clip_a), int'(eca));
    chk("clip_b", int'(clip_b), int'(ecb));
    chk("overrun_a", int'(ov_a), int'(ov));
    chk("overrun_b", int'(ov_b), int'(ov));
    if (vld_a === 1'b1) begin
      last_a = int'(samp_a); last_b = int'(samp_b);
      last_ca = clip_a; last_cb = clip_b;
      last_vcyc = cyc; nvld_a++;
    end
    rst = r;
    bus.frame_start = fs;
    bus.mo_sample = ms; bus.mo = mv[9:0];
    bus.ro_sample = rs; bus.ro = rv[9:0];
    if (r) begin
      model_reset();
    end else if (!synced) begin
      synced = fs;
    end else begin
      if (fs) begin
        ta = mo_sum * GA_MO + ro_sum * GA_RO;
        tb = mo_sum * GB_MO + ro_sum * GB_RO;
        x.due = cyc + 2;
        x.sa = sat16(ta); x.ca = (x.sa != ta);
        x.sb = sat16(tb); x.cb = (x.sb != tb);
        pend.push_back(x);
        mo_sum = 0; mo_n = 0; ro_sum = 0; ro_n = 0;
      end
      if (ms) begin
        if (mo_n == SLOTS_PER_CH) ov = 1;
        else begin mo_sum += mv; mo_n++; end
      end
      if (rs) begin
        if (ro_n == SLOTS_PER_CH) ov = 1;
        else begin ro_sum += rv; ro_n++; end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic frame_start_now();
    last_fs = cyc;
    step(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    int since_fs;
    int n0;
    logic [9:0] r10a, r10b;
    bit r, fs, ms, rs;

    rst = 1'b1;
    bus.frame_start = 0; bus.mo_sample = 0; bus.mo = '0;
    bus.ro_sample = 0; bus.ro = '0;
    last_a = 0; last_b = 0; last_vcyc = -100; last_fs = 0; nvld_a = 0;
    last_ca = 0; last_cb = 0;
    model_reset();
    repeat (2) @(posedge clk);

    step(1, 0, 0, 0, 0, 0);
    idle(2);

    // Strobes before sync are dropped, including one riding on the sync pulse.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 50, 1, -20);
    step(0, 1, 1, 50, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 100, 0, 0);
    frame_start_now();
    idle(3);
    chk("r029_sample", last_a, 900);
    chk("r029_latency", last_vcyc - last_fs, 2);
    chk("r029_clip", int'(last_ca), 0);

    for (int i = 0; i < 9; i++) step(0, 0, 1, 511, 1, 511);
    frame_start_now();
    idle(3);
    chk("r030_pos_sample", last_b, 32767);
    chk("r030_pos_clip", int'(last_cb), 1);
    for (int i = 0; i < 9; i++) step(0, 0, 1, -512, 1, -512);
    frame_start_now();
    idle(3);
    chk("r030_neg_sample", last_b, -32768);
    chk("r030_neg_clip", int'(last_cb), 1);

    for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 0, 0);
    frame_start_now();
    idle(3);
    chk("r031_sample", last_a, 9 * GA_MO);
    chk("r031_overrun", int'(ov_a), 1);
    idle(15);
    frame_start_now();
    idle(3);
    chk("r031_overrun_sticky", int'(ov_a), 1);

    step(0, 0, 1, 3, 0, 0);
    last_fs = cyc;
    step(0, 1, 1, 7, 0, 0);
    idle(3);
    chk("r032_excluded", last_a, 3);
    frame_start_now();
    idle(3);
    chk("r032_included", last_a, 7);

    for (int i = 0; i < 3; i++) step(0, 0, 1, 5, 1, 5);
    step(1, 0, 1, 5, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("r033_sample", int'(samp_a), 0);
    chk("r033_overrun", int'(ov_a), 0);
    n0 = nvld_a;
    step(0, 1, 0, 0, 0, 0);
    idle(4);
    chk("r033_no_valid", nvld_a - n0, 0);
    step(0, 0, 1, -200, 1, 100);
    frame_start_now();
    idle(3);
    chk("r033_resume", last_a, -200 * GA_MO + 100 * GA_RO);

    since_fs = 0;
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 399) == 0);
      fs = (since_fs >= 17) || ($urandom_range(0, 29) == 0);
      ms = ($urandom_range(0, 99) < 45);
      rs = ($urandom_range(0, 99) < 45);
      r10a = 10'($urandom);
      r10b = 10'($urandom);
      step(r, fs, ms, int'($signed(r10a)), rs, int'($signed(r10b)));
      since_fs = fs ? 0 : since_fs + 1;
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
